// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } pc_state_e;

    localparam int unsigned PC_STEP_FULL = 32'd4;
    localparam int unsigned PC_STEP_HALF = 32'd2;

    // Selects the PC increment for an accepted fetch.
    function automatic int unsigned pc_step(input logic c_ext, input logic step_half);
        if (c_ext && step_half) begin
            return PC_STEP_HALF;
        end else begin
            return PC_STEP_FULL;
        end
    endfunction

endpackage

// File: rtl/pc_align_chk.sv
// Combinational check that a redirect target lies on a legal instruction boundary.
module pc_align_chk #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned C_EXT = 0
) (
    input  logic [XLEN-1:0] addr_i,
    output logic            aligned_o
);

    // Halfword boundary with compressed instructions, word boundary otherwise.
    localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

    // Target is aligned when every masked low bit is clear.
    always_comb begin
        aligned_o = ((addr_i & ALIGN_MASK) == {XLEN{1'b0}});
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot, sequential fetch, stall, redirect and halt-on-misalign.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int unsigned     C_EXT      = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            reboot_i,
    input  logic [XLEN-1:0] boot_addr_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_addr_i,
    input  logic            jump_valid_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            hold_i,
    input  logic            step_half_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    output logic            misalign_o,
    output logic            halted_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            trap_ok_s;
    logic            jump_ok_s;
    logic [XLEN-1:0] step_s;

    pc_align_chk #(.XLEN(XLEN), .C_EXT(C_EXT)) u_trap_chk (
        .addr_i    (trap_addr_i),
        .aligned_o (trap_ok_s)
    );

    pc_align_chk #(.XLEN(XLEN), .C_EXT(C_EXT)) u_jump_chk (
        .addr_i    (jump_addr_i),
        .aligned_o (jump_ok_s)
    );

    // Increment applied to the PC when a fetch is accepted.
    always_comb begin
        step_s = XLEN'(pc_step(C_EXT != 0, step_half_i));
    end

    // Next-state and next-PC selection in priority order.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (reboot_i) begin
            state_d = ST_BOOT;
        end else if (state_q == ST_BOOT) begin
            pc_d    = boot_addr_i;
            state_d = ST_RUN;
        end else if (trap_valid_i) begin
            if (trap_ok_s) begin
                pc_d    = trap_addr_i;
                state_d = ST_RUN;
            end else begin
                misalign_d = 1'b1;
                state_d    = ST_HALT;
            end
        end else if (jump_valid_i && (state_q != ST_HALT)) begin
            if (jump_ok_s) begin
                pc_d    = jump_addr_i;
                state_d = ST_RUN;
            end else begin
                misalign_d = 1'b1;
                state_d    = ST_HALT;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A stall outranks the handshake, so the PC does not move.
                    if (hold_i) begin
                        state_d = ST_HOLD;
                    end else if (req_ready_i) begin
                        pc_d = pc_q + step_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                ST_HOLD: begin
                    if (!hold_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // State, PC and misalign-pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_ADDR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs decode registered state only; nothing depends on req_ready_i combinationally.
    always_comb begin
        req_valid_o = (state_q == ST_RUN);
        halted_o    = (state_q == ST_HALT);
        req_addr_o  = pc_q;
        misalign_o  = misalign_q;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: two instances (word-only and compressed) checked against a rule model.
module tb_pc_gen;

    localparam logic [31:0] RST_A0 = 32'h0000_0000;
    localparam logic [31:0] RST_A1 = 32'h0000_1000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_HALT = 3;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        m;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reboot, trap_v, jump_v, hold, half, ready;
    logic [31:0] boot_a, trap_a, jump_a;
    logic        v0, m0, h0, v1, m1, h1;
    logic [31:0] a0, a1;

    int          errors = 0;
    int          checks = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          mode[2];
    logic [31:0] mpc[2];
    logic        mmis[2];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_ADDR(RST_A0), .C_EXT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .reboot_i(reboot), .boot_addr_i(boot_a),
        .trap_valid_i(trap_v), .trap_addr_i(trap_a), .jump_valid_i(jump_v),
        .jump_addr_i(jump_a), .hold_i(hold), .step_half_i(half),
        .req_valid_o(v0), .req_ready_i(ready), .req_addr_o(a0),
        .misalign_o(m0), .halted_o(h0)
    );

    pc_gen #(.XLEN(32), .RESET_ADDR(RST_A1), .C_EXT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .reboot_i(reboot), .boot_addr_i(boot_a),
        .trap_valid_i(trap_v), .trap_addr_i(trap_a), .jump_valid_i(jump_v),
        .jump_addr_i(jump_a), .hold_i(hold), .step_half_i(half),
        .req_valid_o(v1), .req_ready_i(ready), .req_addr_o(a1),
        .misalign_o(m1), .halted_o(h1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic bit target_ok(input bit cext, input logic [31:0] t);
        if (cext) return (t % 2) == 0;
        return (t % 4) == 0;
    endfunction

    task automatic redirect(input int k, input bit cext, input logic [31:0] t);
        if (target_ok(cext, t)) begin
            mpc[k]  = t;
            mode[k] = M_RUN;
        end else begin
            mmis[k] = 1'b1;
            mode[k] = M_HALT;
        end
    endtask

    // Advance the behavioural model by one clock edge using the inputs at that edge.
    task automatic model_step(input int k, input bit cext, input logic [31:0] rst_addr);
        mmis[k] = 1'b0;
        if (!rst_n) begin
            mode[k] = M_BOOT;
            mpc[k]  = rst_addr;
        end else if (reboot) begin
            mode[k] = M_BOOT;
        end else if (mode[k] == M_BOOT) begin
            mpc[k]  = boot_a;
            mode[k] = M_RUN;
        end else if (trap_v) begin
            redirect(k, cext, trap_a);
        end else if (jump_v && mode[k] != M_HALT) begin
            redirect(k, cext, jump_a);
        end else if (mode[k] == M_HALT) begin
            mode[k] = M_HALT;
        end else if (hold) begin
            mode[k] = M_HOLD;
        end else if (mode[k] == M_HOLD) begin
            mode[k] = M_RUN;
        end else if (ready) begin
            mpc[k] = mpc[k] + ((cext && half) ? 32'd2 : 32'd4);
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.v = (mode[k] == M_RUN);
        e.h = (mode[k] == M_HALT);
        e.a = mpc[k];
        e.m = mmis[k];
        return e;
    endfunction

    // One clock: model both instances at the edge, queue expectations, then move off the edge.
    task automatic tick();
        @(posedge clk);
        model_step(0, 1'b0, RST_A0);
        model_step(1, 1'b1, RST_A1);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        #1;
    endtask

    task automatic idle();
        reboot = 1'b0; trap_v = 1'b0; jump_v = 1'b0;
        hold = 1'b0; half = 1'b0; ready = 1'b1;
    endtask

    // Monitor: compare presented outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0.req_valid", 32'(v0), 32'(e.v));
            check("dut0.req_addr", a0, e.a);
            check("dut0.misalign", 32'(m0), 32'(e.m));
            check("dut0.halted", 32'(h0), 32'(e.h));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1.req_valid", 32'(v1), 32'(e.v));
            check("dut1.req_addr", a1, e.a);
            check("dut1.misalign", 32'(m1), 32'(e.m));
            check("dut1.halted", 32'(h1), 32'(e.h));
        end
    end

    initial begin
        rst_n  = 1'b0;
        boot_a = 32'h8000_0000;
        trap_a = 32'h0;
        jump_a = 32'h0;
        idle();
        repeat (3) tick();
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (5) tick();

        // stall three cycles at 0x10, then accept
        jump_v = 1'b1; jump_a = 32'h10; tick();
        jump_v = 1'b0; ready = 1'b0; repeat (3) tick();
        ready = 1'b1; repeat (2) tick();

        // one halfword step at 0x100
        jump_v = 1'b1; jump_a = 32'h100; tick();
        jump_v = 1'b0; half = 1'b1; tick();
        half = 1'b0; repeat (2) tick();

        // jump while held and not ready
        hold = 1'b1; tick();
        jump_v = 1'b1; jump_a = 32'h200; ready = 1'b0; tick();
        idle(); tick();

        // trap outranks jump
        trap_v = 1'b1; trap_a = 32'h40; jump_v = 1'b1; jump_a = 32'h80; tick();
        idle(); tick();

        // misaligned jump halts the word-only instance; jump ignored in halt; trap resumes
        jump_v = 1'b1; jump_a = 32'h202; tick();
        idle(); tick();
        jump_v = 1'b1; jump_a = 32'h300; tick();
        idle(); repeat (2) tick();
        trap_v = 1'b1; trap_a = 32'h40; tick();
        idle(); repeat (2) tick();

        // wrap at the top of the address space
        jump_v = 1'b1; jump_a = 32'hFFFF_FFFC; tick();
        idle(); repeat (2) tick();
        jump_v = 1'b1; jump_a = 32'hFFFF_FFFE; tick();
        jump_v = 1'b0; half = 1'b1; tick();
        idle(); tick();

        // reboot to a new boot address
        boot_a = 32'h0000_2000; reboot = 1'b1; tick();
        reboot = 1'b0; repeat (3) tick();

        // asynchronous reset mid-operation
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check("rst_abort.dut0.req_valid", 32'(v0), 32'd0);
        check("rst_abort.dut1.req_valid", 32'(v1), 32'd0);
        check("rst_abort.dut0.req_addr", a0, RST_A0);
        check("rst_abort.dut1.req_addr", a1, RST_A1);
        tick(); tick();
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [31:0] r;
            reboot = ($urandom_range(0, 31) == 0);
            trap_v = ($urandom_range(0, 15) == 0);
            jump_v = ($urandom_range(0, 7) == 0);
            hold   = ($urandom_range(0, 3) == 0);
            ready  = ($urandom_range(0, 3) != 0);
            half   = $urandom_range(0, 1);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            jump_a = r;
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            trap_a = r;
            r = $urandom;
            boot_a = {r[31:2], 2'b00};
            tick();
        end
        idle();
        repeat (3) tick();
        @(negedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
